// File: rtl/countdown_seg7_timer_pkg.sv
// Shared constants and types for the countdown display path.
// SEG_DIGIT holds the active-low gfedcba patterns for 0..9.
// SEG_BLANK turns every segment off.
// cd_state_t is the timer FSM state encoding.
package traffic_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} cd_state_t;

endpackage

// File: rtl/countdown_seg7_timer_if.sv
// Bundle of control and display signals for countdown_seg7_timer.
//   master: drives load/load_value/start/pause and observes the outputs.
//   slave : the timer itself.
interface countdown_seg7_timer_if #(
    parameter int NUM_DIGITS = 2
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_value;
    logic                    start;
    logic                    pause;
    logic [7*NUM_DIGITS-1:0] hex_out;
    logic                    running;
    logic                    done;

    modport master (output load, load_value, start, pause,
                    input  hex_out, running, done);
    modport slave  (input  load, load_value, start, pause,
                    output hex_out, running, done);
endinterface

// File: rtl/countdown_seg7_timer_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder (gfedcba).
//   bcd   : digit value; codes 10..15 display as blank
//   blank : force all segments off
//   seg   : segment drive
module bcd_to_seg7
    import traffic_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (!blank && bcd <= 4'd9) seg = SEG_DIGIT[bcd];
    end
endmodule

// File: rtl/countdown_seg7_timer.sv
// BCD countdown timer with registered N-digit 7-segment drive.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : load/load_value/start/pause in, hex_out/running/done out
// Optional feature: define COUNTDOWN_BLINK_EN to blink the "0" display
// in DONE on every prescaler wrap; otherwise DONE shows a static "0"
// and the prescaler is held at 0.
// Outputs are flops loaded from the next-state values, so they change
// on the same edge as the count/state they describe.
module countdown_seg7_timer
    import traffic_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    countdown_seg7_timer_if.slave bus
);
    localparam int             PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

    cd_state_t                   state_q, state_d;
    logic [NUM_DIGITS-1:0][3:0]  count_q, count_d, load_bcd, dec_val;
    logic [PW-1:0]               presc_q, presc_d;
    logic                        blink_q, blink_d;
    logic [NUM_DIGITS-1:0]       blank;
    logic [NUM_DIGITS-1:0][6:0]  seg;
    logic [7*NUM_DIGITS-1:0]     hex_q;
    logic                        running_q, done_q;
    logic                        borrow, lead, count_zero, dec_zero, wrap;

    // Load sanitising and BCD borrow-chain decrement.
    always_comb begin
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_bcd[i] = (bus.load_value[i*4 +: 4] > 4'd9) ? 4'd0 : bus.load_value[i*4 +: 4];
            dec_val[i]  = count_q[i];
            if (borrow) begin
                if (count_q[i] == 4'd0) begin
                    dec_val[i] = 4'd9;
                end else begin
                    dec_val[i] = count_q[i] - 4'd1;
                    borrow     = 1'b0;
                end
            end
        end
        count_zero = (count_q == '0);
        dec_zero   = (dec_val == '0);
        wrap       = (presc_q == PRESC_MAX);
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        blink_d = blink_q;
        if (bus.load) begin
            count_d = load_bcd;
            presc_d = '0;
            blink_d = 1'b0;
            state_d = bus.start ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (!bus.pause && bus.start) begin
                    presc_d = '0;
                    state_d = count_zero ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (count_zero) begin
                        // only reachable through load+start with a zero value
                        presc_d = '0;
                        state_d = ST_DONE;
                    end else if (wrap) begin
                        presc_d = '0;
                        count_d = dec_val;
                        if (dec_zero) state_d = ST_DONE;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_PAUSE: if (!bus.pause && bus.start) state_d = ST_RUN;
                ST_DONE: begin
`ifdef COUNTDOWN_BLINK_EN
                    if (wrap) begin
                        presc_d = '0;
                        blink_d = !blink_q;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
`else
                    presc_d = '0;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Leading-zero blanking from the top digit down; digit0 only blanks
    // during the off phase of the DONE blink.
    always_comb begin
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead     = lead && (count_d[i] == 4'd0);
            blank[i] = lead || blink_d;
        end
        blank[0] = blink_d;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_to_seg7 u_seg (.bcd(count_d[g]), .blank(blank[g]), .seg(seg[g]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            presc_q    <= '0;
            blink_q    <= 1'b0;
            hex_q      <= {NUM_DIGITS{SEG_BLANK}};
            hex_q[6:0] <= SEG_DIGIT[0];
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            blink_q   <= blink_d;
            hex_q     <= seg;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE) && (state_q != ST_DONE);
        end
    end

    assign bus.hex_out = hex_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_seg7_timer.sv
module tb_countdown_seg7_timer;
    localparam int B = 10;  // blank digit code for sg()

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   nchk  = 0;
    int   nerr  = 0;

    always #5 clk = ~clk;

    countdown_seg7_timer_if #(.NUM_DIGITS(2)) if2 ();
    countdown_seg7_timer_if #(.NUM_DIGITS(3)) if3 ();

    countdown_seg7_timer #(.NUM_DIGITS(2), .TICK_DIV(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    countdown_seg7_timer #(.NUM_DIGITS(3), .TICK_DIV(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    typedef struct {
        string      nm;
        logic       ld;
        logic [7:0] lv;
        logic       st;
        logic       pa;
        logic [13:0] hex;
        logic       run;
        logic       dn;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [6:0] sg(int d);
        case (d)
            0: sg = 7'b1000000;  1: sg = 7'b1111001;  2: sg = 7'b0100100;
            3: sg = 7'b0110000;  4: sg = 7'b0011001;  5: sg = 7'b0010010;
            6: sg = 7'b0000010;  7: sg = 7'b1111000;  8: sg = 7'b0000000;
            9: sg = 7'b0010000;  default: sg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] hx2(int t, int o);
        return {sg(t), sg(o)};
    endfunction

    function automatic logic [13:0] hxv(int v);
        return hx2((v / 10 == 0) ? B : v / 10, v % 10);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk2(string nm, logic [13:0] h, logic r, logic d);
        chk({nm, ".hex"},  32'(if2.hex_out), 32'(h));
        chk({nm, ".run"},  32'(if2.running), 32'(r));
        chk({nm, ".done"}, 32'(if2.done),    32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if2.load = 0; if2.load_value = '0; if2.start = 0; if2.pause = 0;
        if3.load = 0; if3.load_value = '0; if3.start = 0; if3.pause = 0;

        tbl[0]  = '{"ld12",    1, 8'h12, 0, 0, hx2(1, 2), 0, 0};
        tbl[1]  = '{"ld3A",    1, 8'h3A, 0, 0, hx2(3, 0), 0, 0};
        tbl[2]  = '{"ld07",    1, 8'h07, 0, 0, hx2(B, 7), 0, 0};
        tbl[3]  = '{"ldF5",    1, 8'hF5, 0, 0, hx2(B, 5), 0, 0};
        tbl[4]  = '{"ld00",    1, 8'h00, 0, 0, hx2(B, 0), 0, 0};
        tbl[5]  = '{"st0",     0, 8'h00, 1, 0, hx2(B, 0), 0, 1};
        tbl[6]  = '{"done1",   0, 8'h00, 0, 0, hx2(B, 0), 0, 0};
        tbl[7]  = '{"stdone",  0, 8'h00, 1, 0, hx2(B, 0), 0, 0};
        tbl[8]  = '{"ld98",    1, 8'h98, 0, 0, hx2(9, 8), 0, 0};
        tbl[9]  = '{"ldst46",  1, 8'h46, 1, 0, hx2(4, 6), 1, 0};
        tbl[10] = '{"pause",   0, 8'h00, 0, 1, hx2(4, 6), 0, 0};
        tbl[11] = '{"pa_st",   0, 8'h00, 1, 1, hx2(4, 6), 0, 0};
        tbl[12] = '{"resume",  0, 8'h00, 1, 0, hx2(4, 6), 1, 0};
        tbl[13] = '{"ldst00",  1, 8'h00, 1, 0, hx2(B, 0), 1, 0};
        tbl[14] = '{"run0",    0, 8'h00, 0, 0, hx2(B, 0), 0, 1};
        tbl[15] = '{"clr",     1, 8'h00, 0, 0, hx2(B, 0), 0, 0};
        tbl[16] = '{"ld25",    1, 8'h25, 0, 0, hx2(2, 5), 0, 0};
        tbl[17] = '{"idle_pa", 0, 8'h00, 1, 1, hx2(2, 5), 0, 0};

        // reset state
        #2 rst_n = 0;
        #2;
        chk2("rst", hx2(B, 0), 0, 0);
        chk("rst3.hex", 32'(if3.hex_out), 32'({sg(B), sg(B), sg(0)}));
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // table-driven single-cycle vectors
        for (int i = 0; i < 18; i++) begin
            if2.load = tbl[i].ld; if2.load_value = tbl[i].lv;
            if2.start = tbl[i].st; if2.pause = tbl[i].pa;
            tick();
            chk2(tbl[i].nm, tbl[i].hex, tbl[i].run, tbl[i].dn);
        end
        if2.load = 0; if2.start = 0; if2.pause = 0;

        // full countdown from 12, one step per 4 clocks
        if2.load = 1; if2.load_value = 8'h12; tick();
        if2.load = 0; if2.start = 1; tick();
        if2.start = 0;
        chk2("cnt.start", hxv(12), 1, 0);
        for (int k = 1; k <= 48; k++) begin
            tick();
            chk2("cnt", hxv(12 - k / 4), (k < 48), (k == 48));
            if (k == 12) chk("show09", 32'(if2.hex_out), 32'({7'b1111111, 7'b0010000}));
        end
        // DONE display, blinking or static
        for (int j = 1; j <= 8; j++) begin
            tick();
`ifdef COUNTDOWN_BLINK_EN
            chk2("blink", (((j / 4) % 2) == 1) ? hx2(B, B) : hx2(B, 0), 0, 0);
`else
            chk2("dstatic", hx2(B, 0), 0, 0);
`endif
        end

        // 3-digit borrow across two zero digits
        if3.load = 1; if3.load_value = 12'h100; tick();
        if3.load = 0; if3.start = 1; tick();
        if3.start = 0;
        chk("b3.run", 32'(if3.running), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) chk("b3.100", 32'(if3.hex_out), 32'({sg(1), sg(0), sg(0)}));
        end
        chk("b3.099", 32'(if3.hex_out), 32'({sg(B), sg(9), sg(9)}));

        // pause mid-prescale: 10 non-advancing cycles stretch the step to 14
        if2.load = 1; if2.load_value = 8'h05; tick();
        if2.load = 0; if2.start = 1; tick();
        if2.start = 0;
        tick(); tick();
        if2.pause = 1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk2("paused", hx2(B, 5), 0, 0);
        end
        if2.pause = 0; if2.start = 1; tick();
        if2.start = 0;
        chk2("resume", hx2(B, 5), 1, 0);
        tick();
        chk2("res.pre", hx2(B, 5), 1, 0);
        tick();
        chk2("res.tick", hx2(B, 4), 1, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk2("res.next", hx2(B, (k == 4) ? 3 : 4), 1, 0);
        end

        // asynchronous reset mid-run: immediate reset values, no done pulse
        tick();
        rst_n = 0;
        #1;
        chk2("rstrun", hx2(B, 0), 0, 0);
        tick(); tick();
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk2("postrst", hx2(B, 0), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
